memory_ctrl: RTL and testbench
==============================

Name: memory_ctrl

Overview:
Byte-addressed 64-bit-word buffer controller in front of a single synchronous RAM, used by the NTS engine as packet TX/RX buffer memory. Supports aligned and unaligned (any byte offset 0..7) 64-bit reads and writes, using big-endian byte order (byte 0 = bits 63:56). Unaligned writes may be streamed back-to-back at consecutive addresses, one per cycle. The RAM can optionally be filled with a constant on reset.

Parameters:
ADDR_WIDTH, 8, word address width; DEPTH = 2**ADDR_WIDTH words of 64 bits.
INIT_ON_RESET, 0, 1 = fill every word with INIT_VALUE after reset.
INIT_VALUE, 64'h0, fill value used when INIT_ON_RESET = 1.

Ports:
i_clk  in  1  clock.
i_areset  in  1  reset, asynchronous, active-high.
i_read_64  in  1  read request: 8 bytes starting at byte address {i_addr_hi, i_addr_lo}.
i_write_64  in  1  write request: 8 bytes of i_write_data to the same byte address.
i_write_data  in  64  write data; byte 0 = bits 63:56.
i_addr_hi  in  ADDR_WIDTH  word address.
i_addr_lo  in  3  byte offset within the word.
o_error  out  1  registered one-cycle pulse for a rejected request.
o_busy  out  1  init or write completion in progress.
o_data  out  64  read data.

Behaviour:
- Reset: o_data=0, o_error=0, carry register cleared. o_busy=1 if INIT_ON_RESET (state INIT), else 0 (state IDLE). Reset may occur mid-operation; any pending write is discarded.
- INIT: writes INIT_VALUE to words 0..DEPTH-1, one per cycle (DEPTH cycles), then goes to IDLE and drops o_busy. Requests during INIT are ignored and flag o_error.
- Aligned read (lo=0): o_data = word[hi], registered; valid after the first rising edge that samples the request. One read is accepted per cycle.
- Unaligned read (lo=k): o_data = bytes k..k+7 of {word[hi], word[hi+1]}, in the same 1-cycle latency. Implement with an even/odd-bank or dual-read RAM. When hi = DEPTH-1, word[hi+1] wraps to word 0.
- Aligned write: word[hi] = data in one cycle, with no busy. One aligned write is accepted per cycle.
- Unaligned write, lo = k, n = 8 - k:
  - word[hi] keeps its top k bytes and receives the top n bytes of data in its low bytes.
  - word[hi+1] receives the low k bytes of data in its top bytes and keeps its low n bytes.
- States: IDLE, INIT, UNALIGNED_WRITE64 (stream active, carry valid), UNALIGNED_WRITE64_LAST (read-modify-write of the final word hi+1). Flow:
  1. First unaligned write: read-modify-write of word[hi]. The low-k-byte tail is held in the carry register. o_busy=1. Go to UNALIGNED_WRITE64.
  2. While in UNALIGNED_WRITE64, a write at byte address = previous + 8 (same k) writes full word {carry, new head} to hi with no read, and refreshes the carry. Stalling is never needed.
  3. A cycle with no such write goes to UNALIGNED_WRITE64_LAST: read word[last_hi+1], merge the carry, write it back, then IDLE with o_busy=0.
  4. A single isolated unaligned write must also pass through UNALIGNED_WRITE64_LAST.
- Errors: these requests set o_error for one cycle and are ignored:
  - read and write asserted together;
  - any request while o_busy, other than a stream-continuing write;
  - a non-consecutive write during a stream.
- o_data holds its value when there is no read.
- Reads issued after o_busy falls return fully merged data.

Optional Feature:
MEMORY_CTRL_BOUNDS_CHECK_EN. When defined, an unaligned read or write with i_addr_hi = DEPTH-1 is rejected: o_error pulses, no RAM change, o_data held. When undefined, the word index wraps to 0 (the default behaviour described above).

Decomposition:
- Package memory_ctrl_pkg: state encodings (IDLE, INIT, UNALIGNED_WRITE64, UNALIGNED_WRITE64_LAST) and the byte-lane merge helper function.
- One sub-module memory_ctrl_ram, instanced as "ram". It is a simple synchronous 64-bit RAM with array "ram", readable by hierarchy for debug dumps; the dual read is done via banking inside it.

Test Plan:
1. INIT_ON_RESET=1, INIT_VALUE=64'hF0F1F2F3F4F5F6F7, release reset → o_busy high for 256 cycles, then every word reads 64'hF0F1F2F3F4F5F6F7.
2. Aligned write of pattern(i) to all 256 words, then aligned read of each → o_data == pattern(i) one cycle after the request. pattern(i): top byte 10^i, then bytes 20..80 each XOR i.
3. Unaligned read with lo=1..7, hi=0..254 → o_data = slice of {pattern(hi), pattern(hi+1)}; lo=1 gives bits 119:56.
4. Fill all words with F8F9FAFBFCFDFEFF, stream unaligned writes of pattern(i) at (i, lo=k) for i=0..254, wait for o_busy low:
   - unaligned reads at (i, k) return pattern(i);
   - word 0 = {top k bytes of F8.., pattern(0) top 8-k bytes};
   - word 255 = {pattern(254) low k bytes, low 8-k bytes of F8..FF}.
5. Write 0204006830a8dce1 alone at byte address 0x7E, wait for o_busy low, read 0x7E → 0204006830a8dce1.
6. Assert i_read_64 and i_write_64 together → o_error pulses for 1 cycle, RAM unchanged.

Source files
------------

// File: rtl/memory_ctrl_pkg.sv
// memory_ctrl_pkg: state encoding and big-endian byte-lane helpers shared by memory_ctrl
package memory_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        INIT,
        UNALIGNED_WRITE64,
        UNALIGNED_WRITE64_LAST
    } state_t;

    // Mask covering the low (8 - k) bytes of a word; byte 0 is bits 63:56
    function automatic logic [63:0] low_bytes_mask(input logic [2:0] k);
        return {64{1'b1}} >> {k, 3'b000};
    endfunction

    // Take mask-selected bytes from new_word, the rest from old_word
    function automatic logic [63:0] merge_bytes(input logic [63:0] old_word,
                                                input logic [63:0] new_word,
                                                input logic [63:0] mask);
        return (old_word & ~mask) | (new_word & mask);
    endfunction

    // Bytes k..k+7 of the 16-byte window {hi_word, lo_word}
    function automatic logic [63:0] window_bytes(input logic [63:0] hi_word,
                                                 input logic [63:0] lo_word,
                                                 input logic [2:0]  k);
        return (k == 3'd0) ? hi_word
                           : (hi_word << {k, 3'b000}) | (lo_word >> {3'(3'd0 - k), 3'b000});
    endfunction

endpackage

// File: rtl/memory_ctrl_ram.sv
// memory_ctrl_ram: 64-bit synchronous RAM (array "ram"), one write port and an even/odd banked read of words a and a+1
module memory_ctrl_ram #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  i_clk,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_waddr,
    input  logic [63:0]           i_wdata,
    input  logic [ADDR_WIDTH-1:0] i_raddr,
    output logic [63:0]           o_q0,
    output logic [63:0]           o_q1
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [63:0]           ram [0:DEPTH-1];
    logic [63:0]           r_q_even;
    logic [63:0]           r_q_odd;
    logic                  r_swap;
    logic [ADDR_WIDTH-1:0] w_raddr_next;
    logic [ADDR_WIDTH-1:0] w_even_addr;
    logic [ADDR_WIDTH-1:0] w_odd_addr;

    // Words a and a+1 always fall in opposite banks; a+1 wraps at the top
    assign w_raddr_next = i_raddr + 1'b1;
    assign w_even_addr  = i_raddr[0] ? w_raddr_next : i_raddr;
    assign w_odd_addr   = i_raddr[0] ? i_raddr : w_raddr_next;
    assign o_q0         = r_swap ? r_q_odd : r_q_even;
    assign o_q1         = r_swap ? r_q_even : r_q_odd;

    // Synchronous write and registered read-before-write of both banks
    always_ff @(posedge i_clk) begin
        if (i_we)
            ram[i_waddr] <= i_wdata;
        r_q_even <= ram[w_even_addr];
        r_q_odd  <= ram[w_odd_addr];
        r_swap   <= i_raddr[0];
    end

endmodule

// File: rtl/memory_ctrl.sv
// memory_ctrl: byte-addressed 64-bit read/write controller over a banked RAM; MEMORY_CTRL_BOUNDS_CHECK_EN rejects unaligned access at the last word
module memory_ctrl
    import memory_ctrl_pkg::*;
#(
    parameter int          ADDR_WIDTH    = 8,
    parameter int          INIT_ON_RESET = 0,
    parameter logic [63:0] INIT_VALUE    = 64'h0
) (
    input  logic                  i_clk,
    input  logic                  i_areset,
    input  logic                  i_read_64,
    input  logic                  i_write_64,
    input  logic [63:0]           i_write_data,
    input  logic [ADDR_WIDTH-1:0] i_addr_hi,
    input  logic [2:0]            i_addr_lo,
    output logic                  o_error,
    output logic                  o_busy,
    output logic [63:0]           o_data
);
    state_t                r_state;
    state_t                w_next_state;
    logic [ADDR_WIDTH-1:0] r_hi;
    logic [ADDR_WIDTH-1:0] r_cnt;
    logic [ADDR_WIDTH-1:0] w_hi_next;
    logic [ADDR_WIDTH-1:0] w_waddr;
    logic [ADDR_WIDTH-1:0] w_raddr;
    logic [2:0]            r_k;
    logic [2:0]            r_lo;
    logic [2:0]            w_nk;
    logic [63:0]           r_pend_d;
    logic [63:0]           r_pend_m;
    logic [63:0]           r_carry;
    logic [63:0]           r_hold;
    logic [63:0]           w_wdata;
    logic [63:0]           w_q0;
    logic [63:0]           w_q1;
    logic                  r_fresh;
    logic                  r_error;
    logic                  w_we;
    logic                  w_err;
    logic                  w_req;
    logic                  w_rd_acc;
    logic                  w_wr_acc;
    logic                  w_ua_acc;
    logic                  w_cont;
    logic                  w_oob;

    assign w_hi_next = r_hi + 1'b1;
    assign w_nk      = 3'd0 - i_addr_lo;
    assign w_req     = i_read_64 | i_write_64;
`ifdef MEMORY_CTRL_BOUNDS_CHECK_EN
    assign w_oob     = (i_addr_lo != 3'd0) && (i_addr_hi == {ADDR_WIDTH{1'b1}});
`else
    assign w_oob     = 1'b0;
`endif
    // A stream continues only with a lone write exactly 8 bytes past the previous one
    assign w_cont    = i_write_64 && !i_read_64 && !w_oob &&
                       (i_addr_lo == r_k) && (i_addr_hi == w_hi_next);
    assign o_error   = r_error;
    // Fresh read data comes straight from the RAM registers; otherwise replay the last value
    assign o_data    = r_fresh ? window_bytes(w_q0, w_q1, r_lo) : r_hold;

    memory_ctrl_ram #(.ADDR_WIDTH(ADDR_WIDTH)) ram (
        .i_clk   (i_clk),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata (w_wdata),
        .i_raddr (w_raddr),
        .o_q0    (w_q0),
        .o_q1    (w_q1)
    );

    // State register; reset abandons any write in flight
    always_ff @(posedge i_clk or posedge i_areset) begin
        if (i_areset)
            r_state <= (INIT_ON_RESET != 0) ? INIT : IDLE;
        else
            r_state <= w_next_state;
    end

    // Next-state: fill, idle, stream of full words, final merge of word last_hi+1
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            INIT:              w_next_state = (r_cnt == {ADDR_WIDTH{1'b1}}) ? IDLE : INIT;
            IDLE:              w_next_state = w_ua_acc ? UNALIGNED_WRITE64 : IDLE;
            UNALIGNED_WRITE64: w_next_state = w_cont ? UNALIGNED_WRITE64 : UNALIGNED_WRITE64_LAST;
            default:           w_next_state = IDLE;
        endcase
    end

    // Outputs: request acceptance, error detection and the RAM port controls
    always_comb begin
        o_busy   = r_state != IDLE;
        w_rd_acc = (r_state == IDLE) && i_read_64 && !i_write_64 && !w_oob;
        w_wr_acc = (r_state == IDLE) && i_write_64 && !i_read_64 && !w_oob;
        w_ua_acc = w_wr_acc && (i_addr_lo != 3'd0);
        w_err    = w_req && !w_rd_acc && !w_wr_acc && !((r_state == UNALIGNED_WRITE64) && w_cont);
        w_raddr  = (r_state == UNALIGNED_WRITE64) ? w_hi_next : i_addr_hi;
        w_we     = 1'b0;
        w_waddr  = i_addr_hi;
        w_wdata  = i_write_data;
        case (r_state)
            INIT: begin
                w_we    = 1'b1;
                w_waddr = r_cnt;
                w_wdata = INIT_VALUE;
            end
            IDLE: w_we = w_wr_acc && (i_addr_lo == 3'd0);
            UNALIGNED_WRITE64: begin
                // First word merges with the old head read last cycle; later words are full
                w_we    = 1'b1;
                w_waddr = r_hi;
                w_wdata = merge_bytes(w_q0, r_pend_d, r_pend_m);
            end
            default: begin
                w_we    = 1'b1;
                w_waddr = w_hi_next;
                w_wdata = merge_bytes(w_q0, r_carry, ~low_bytes_mask(r_k));
            end
        endcase
    end

    // Datapath: init counter, read hold, stream head/carry bookkeeping
    always_ff @(posedge i_clk or posedge i_areset) begin
        if (i_areset) begin
            r_error  <= 1'b0;
            r_fresh  <= 1'b0;
            r_hold   <= '0;
            r_cnt    <= '0;
            r_lo     <= '0;
            r_hi     <= '0;
            r_k      <= '0;
            r_carry  <= '0;
            r_pend_d <= '0;
            r_pend_m <= '0;
        end else begin
            r_error <= w_err;
            r_fresh <= w_rd_acc;
            r_hold  <= o_data;
            r_cnt   <= (r_state == INIT) ? r_cnt + 1'b1 : '0;
            if (w_rd_acc)
                r_lo <= i_addr_lo;
            if (w_ua_acc || ((r_state == UNALIGNED_WRITE64) && w_cont)) begin
                r_hi     <= i_addr_hi;
                r_k      <= i_addr_lo;
                r_carry  <= i_write_data << {w_nk, 3'b000};
                r_pend_d <= (w_ua_acc ? 64'd0 : r_carry) | (i_write_data >> {i_addr_lo, 3'b000});
                r_pend_m <= w_ua_acc ? low_bytes_mask(i_addr_lo) : {64{1'b1}};
            end
        end
    end

endmodule

// File: tb/tb_memory_ctrl.sv
// tb_memory_ctrl: randomized self-checking bench for memory_ctrl against a byte-addressed reference memory
module tb_memory_ctrl;
    localparam logic [63:0] INIT_V = 64'hF0F1F2F3F4F5F6F7;
    localparam logic [63:0] FILL_V = 64'hF8F9FAFBFCFDFEFF;

    logic        clk = 1'b0;
    logic        areset = 1'b1;
    logic        rd = 1'b0;
    logic        wr = 1'b0;
    logic [63:0] wdata = '0;
    logic [7:0]  ahi = '0;
    logic [2:0]  alo = '0;
    logic        err;
    logic        busy;
    logic [63:0] dout;
    int          n_cmp = 0;
    int          n_mis = 0;
    logic [63:0] model [256];

    memory_ctrl #(.ADDR_WIDTH(8), .INIT_ON_RESET(1), .INIT_VALUE(INIT_V)) dut (
        .i_clk        (clk),
        .i_areset     (areset),
        .i_read_64    (rd),
        .i_write_64   (wr),
        .i_write_data (wdata),
        .i_addr_hi    (ahi),
        .i_addr_lo    (alo),
        .o_error      (err),
        .o_busy       (busy),
        .o_data       (dout)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic logic [63:0] pattern(input logic [7:0] i);
        return {8'h10 ^ i, 8'h20 ^ i, 8'h30 ^ i, 8'h40 ^ i, 8'h50 ^ i, 8'h60 ^ i, 8'h70 ^ i, 8'h80 ^ i};
    endfunction

    function automatic logic [63:0] model_read(input int baddr);
        logic [63:0] r;
        int a;
        for (int j = 0; j < 8; j++) begin
            a = (baddr + j) % 2048;
            r[63-8*j -: 8] = model[a/8][63-8*(a%8) -: 8];
        end
        return r;
    endfunction

    task automatic model_write(input int baddr, input logic [63:0] d);
        int a;
        for (int j = 0; j < 8; j++) begin
            a = (baddr + j) % 2048;
            model[a/8][63-8*(a%8) -: 8] = d[63-8*j -: 8];
        end
    endtask

    task automatic do_read(input logic [7:0] h, input logic [2:0] l, output logic [63:0] d);
        @(negedge clk);
        rd = 1'b1; wr = 1'b0; ahi = h; alo = l;
        @(posedge clk); #1;
        d = dout;
        rd = 1'b0;
    endtask

    task automatic do_write(input logic [7:0] h, input logic [2:0] l, input logic [63:0] d);
        @(negedge clk);
        wr = 1'b1; rd = 1'b0; ahi = h; alo = l; wdata = d;
        @(posedge clk); #1;
        wr = 1'b0;
        model_write(int'(h) * 8 + int'(l), d);
    endtask

    task automatic wait_idle(input string tag);
        int t = 0;
        while (busy === 1'b1 && t < 400) begin
            @(negedge clk);
            t++;
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            $display("FAIL %s wait_idle: busy=%b after %0d cycles, want 0", tag, busy, t);
            n_mis++;
        end
    endtask

    task automatic test_reset();
        int cycles = 0;
        logic [63:0] d;
        repeat (3) @(negedge clk);
        n_cmp += 3;
        if (busy !== 1'b1) begin $display("FAIL reset_busy: got %b want 1", busy); n_mis++; end
        if (dout !== 64'd0) begin $display("FAIL reset_data: got %h want 0", dout); n_mis++; end
        if (err !== 1'b0) begin $display("FAIL reset_error: got %b want 0", err); n_mis++; end
        areset = 1'b0;
        while (busy === 1'b1 && cycles < 1000) begin
            @(posedge clk); #1;
            cycles++;
        end
        n_cmp++;
        if (cycles != 256) begin $display("FAIL init_busy_cycles: got %0d want 256", cycles); n_mis++; end
        for (int i = 0; i < 256; i++) model[i] = INIT_V;
        for (int i = 0; i < 256; i++) begin
            do_read(8'(i), 3'd0, d);
            n_cmp++;
            if (d !== model[i]) begin $display("FAIL init_word[%0d]: got %h want %h", i, d, model[i]); n_mis++; end
        end
    endtask

    task automatic test_aligned();
        logic [63:0] d;
        for (int i = 0; i < 256; i++) begin
            do_write(8'(i), 3'd0, pattern(8'(i)));
            n_cmp++;
            if (busy !== 1'b0 || err !== 1'b0) begin
                $display("FAIL aligned_write_status[%0d]: busy=%b err=%b want 0 0", i, busy, err); n_mis++;
            end
        end
        for (int i = 0; i < 256; i++) begin
            do_read(8'(i), 3'd0, d);
            n_cmp++;
            if (d !== model[i]) begin $display("FAIL aligned_read[%0d]: got %h want %h", i, d, model[i]); n_mis++; end
        end
        @(negedge clk);
        @(posedge clk); #1;
        n_cmp++;
        if (dout !== model[255]) begin $display("FAIL read_hold: got %h want %h", dout, model[255]); n_mis++; end
    endtask

    task automatic test_unaligned_read();
        logic [63:0]  d;
        logic [127:0] w;
        logic [7:0]   h;
        logic [2:0]   l;
        for (int l0 = 1; l0 < 8; l0++)
            for (int h0 = 0; h0 < 255; h0++) begin
                do_read(8'(h0), 3'(l0), d);
                n_cmp++;
                if (d !== model_read(h0 * 8 + l0)) begin
                    $display("FAIL unaligned_read[%0d,%0d]: got %h want %h", h0, l0, d, model_read(h0 * 8 + l0)); n_mis++;
                end
            end
        w = {pattern(8'd5), pattern(8'd6)};
        do_read(8'd5, 3'd1, d);
        n_cmp++;
        if (d !== w[119:56]) begin $display("FAIL unaligned_lo1: got %h want %h", d, w[119:56]); n_mis++; end
        for (int i = 0; i < 100; i++) begin
            h = 8'($urandom_range(0, 255));
            l = 3'($urandom_range(0, 7));
            do_read(h, l, d);
            n_cmp++;
            if (d !== model_read(int'(h) * 8 + int'(l))) begin
                $display("FAIL rand_read[%0d,%0d]: got %h want %h", h, l, d, model_read(int'(h) * 8 + int'(l))); n_mis++;
            end
        end
    endtask

    task automatic test_stream();
        logic [63:0] d;
        logic [63:0] ones = '1;
        logic [63:0] exp;
        int k = $urandom_range(1, 7);
        for (int i = 0; i < 256; i++) do_write(8'(i), 3'd0, FILL_V);
        for (int i = 0; i < 255; i++) begin
            do_write(8'(i), 3'(k), pattern(8'(i)));
            n_cmp++;
            if (busy !== 1'b1 || err !== 1'b0) begin
                $display("FAIL stream_status[%0d]: busy=%b err=%b want 1 0", i, busy, err); n_mis++;
            end
        end
        wait_idle("stream");
        for (int i = 0; i < 255; i++) begin
            do_read(8'(i), 3'(k), d);
            n_cmp++;
            if (d !== pattern(8'(i))) begin $display("FAIL stream_read[%0d,k=%0d]: got %h want %h", i, k, d, pattern(8'(i))); n_mis++; end
        end
        exp = (FILL_V & ~(ones >> (8 * k))) | (pattern(8'd0) >> (8 * k));
        do_read(8'd0, 3'd0, d);
        n_cmp++;
        if (d !== exp) begin $display("FAIL stream_word0[k=%0d]: got %h want %h", k, d, exp); n_mis++; end
        exp = (pattern(8'd254) << (8 * (8 - k))) | (FILL_V & (ones >> (8 * k)));
        do_read(8'd255, 3'd0, d);
        n_cmp++;
        if (d !== exp) begin $display("FAIL stream_word255[k=%0d]: got %h want %h", k, d, exp); n_mis++; end
    endtask

    task automatic test_isolated();
        logic [63:0] d;
        do_write(8'h0F, 3'd6, 64'h0204006830a8dce1);
        wait_idle("isolated");
        do_read(8'h0F, 3'd6, d);
        n_cmp++;
        if (d !== 64'h0204006830a8dce1) begin $display("FAIL isolated_read: got %h want 0204006830a8dce1", d); n_mis++; end
        for (int i = 15; i < 17; i++) begin
            do_read(8'(i), 3'd0, d);
            n_cmp++;
            if (d !== model[i]) begin $display("FAIL isolated_word[%0d]: got %h want %h", i, d, model[i]); n_mis++; end
        end
    endtask

    task automatic test_read_write_collision();
        logic [63:0] d;
        logic [7:0]  h = 8'($urandom_range(0, 254));
        @(negedge clk);
        rd = 1'b1; wr = 1'b1; ahi = h; alo = 3'($urandom_range(0, 7)); wdata = {$urandom, $urandom};
        @(posedge clk); #1;
        rd = 1'b0; wr = 1'b0;
        n_cmp++;
        if (err !== 1'b1) begin $display("FAIL collision_error: got %b want 1", err); n_mis++; end
        @(posedge clk); #1;
        n_cmp += 2;
        if (err !== 1'b0) begin $display("FAIL collision_pulse: got %b want 0", err); n_mis++; end
        if (busy !== 1'b0) begin $display("FAIL collision_busy: got %b want 0", busy); n_mis++; end
        for (int i = 0; i < 2; i++) begin
            do_read(8'(int'(h) + i), 3'd0, d);
            n_cmp++;
            if (d !== model[int'(h) + i]) begin $display("FAIL collision_word[%0d]: got %h want %h", int'(h) + i, d, model[int'(h) + i]); n_mis++; end
        end
    endtask

    task automatic test_busy_errors();
        logic [63:0] d;
        logic [63:0] prev;
        logic [7:0]  h = 8'($urandom_range(0, 200));
        logic [2:0]  k = 3'($urandom_range(1, 7));
        do_write(h, k, {$urandom, $urandom});
        prev = dout;
        @(negedge clk);
        rd = 1'b1; ahi = 8'(h + 1); alo = 3'd0;
        @(posedge clk); #1;
        rd = 1'b0;
        n_cmp += 2;
        if (err !== 1'b1) begin $display("FAIL busy_read_error: got %b want 1", err); n_mis++; end
        if (dout !== prev) begin $display("FAIL busy_read_hold: got %h want %h", dout, prev); n_mis++; end
        wait_idle("busy_read");
        do_read(h, k, d);
        n_cmp++;
        if (d !== model_read(int'(h) * 8 + int'(k))) begin $display("FAIL busy_read_data: got %h want %h", d, model_read(int'(h) * 8 + int'(k))); n_mis++; end
        h = 8'(h + 20);
        do_write(h, k, {$urandom, $urandom});
        @(negedge clk);
        wr = 1'b1; ahi = 8'(h + 2); alo = k; wdata = {$urandom, $urandom};
        @(posedge clk); #1;
        wr = 1'b0;
        n_cmp++;
        if (err !== 1'b1) begin $display("FAIL skip_write_error: got %b want 1", err); n_mis++; end
        wait_idle("skip_write");
        for (int i = 0; i < 4; i++) begin
            do_read(8'(int'(h) + i), 3'd0, d);
            n_cmp++;
            if (d !== model[int'(h) + i]) begin $display("FAIL skip_write_word[%0d]: got %h want %h", int'(h) + i, d, model[int'(h) + i]); n_mis++; end
        end
        h = 8'(h + 20);
        do_write(h, k, {$urandom, $urandom});
        @(posedge clk); #1;
        n_cmp++;
        if (busy !== 1'b1) begin $display("FAIL last_busy: got %b want 1", busy); n_mis++; end
        @(negedge clk);
        wr = 1'b1; ahi = 8'(h + 1); alo = k; wdata = {$urandom, $urandom};
        @(posedge clk); #1;
        wr = 1'b0;
        n_cmp++;
        if (err !== 1'b1) begin $display("FAIL late_write_error: got %b want 1", err); n_mis++; end
        wait_idle("late_write");
        do_read(8'(h + 1), 3'd0, d);
        n_cmp++;
        if (d !== model[int'(h) + 1]) begin $display("FAIL late_write_word: got %h want %h", d, model[int'(h) + 1]); n_mis++; end
    endtask

    task automatic test_random();
        logic [63:0] d;
        logic [7:0]  h;
        logic [2:0]  l;
        int          op;
        int          len;
        for (int i = 0; i < 80; i++) begin
            op = $urandom_range(0, 3);
            h = 8'($urandom_range(0, 255));
            l = 3'($urandom_range(1, 7));
            if (op == 0)
                do_write(h, 3'd0, {$urandom, $urandom});
            else if (op == 1) begin
                len = $urandom_range(1, 4);
                for (int j = 0; j < len; j++) do_write(8'(int'(h) + j), l, {$urandom, $urandom});
                wait_idle("rand_stream");
            end else begin
                if (op == 2) l = 3'd0;
                do_read(h, l, d);
                n_cmp++;
                if (d !== model_read(int'(h) * 8 + int'(l))) begin
                    $display("FAIL rand_mix_read[%0d,%0d]: got %h want %h", h, l, d, model_read(int'(h) * 8 + int'(l))); n_mis++;
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_aligned();
        test_unaligned_read();
        test_stream();
        test_isolated();
        test_read_write_collision();
        test_busy_errors();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
